temp_monitor_spi_core: RTL and testbench

Top-level TinyTapeout-style block that periodically reads an LM70-family SPI temperature sensor and publishes the 8 temperature MSBs (2 °C/LSB) on the dedicated outputs. It drives CS and SCK, samples SIO, and latches each completed frame. An optional over-temperature alarm compares the reading against a threshold on `ui_in`.

---
 rtl/temp_monitor_pkg.sv | 15 +
 rtl/temp_monitor_spi_core_if.sv | 10 +
 rtl/temp_monitor_spi_core_spi_rx8.sv | 67 ++++++
 rtl/temp_monitor_spi_core.sv | 60 ++++++
 tb/tb_temp_monitor_spi_core.sv | 128 ++++++++++++
 5 files changed

// File: rtl/temp_monitor_pkg.sv
// temp_monitor_pkg: shared FSM state, uio bit map and output-enable constant.
// The alarm output is enabled by defining TEMP_MONITOR_ALARM_EN.
package temp_monitor_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;
  localparam int UIO_CS = 0;
  localparam int UIO_SCK = 1;
  localparam int UIO_SIO = 2;
  localparam int UIO_ALARM = 3;
  localparam int UIO_VALID = 4;
`ifdef TEMP_MONITOR_ALARM_EN
  localparam logic [7:0] UIO_OE = 8'b0001_1011;
`else
  localparam logic [7:0] UIO_OE = 8'b0001_0011;
`endif
endpackage

// File: rtl/temp_monitor_spi_core_if.sv
// temp_monitor_spi_core_if: TinyTapeout-style pin bundle between the core and its environment.
interface temp_monitor_spi_core_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport slave (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
endinterface

// File: rtl/temp_monitor_spi_core_spi_rx8.sv
// spi_rx8: one 8-bit SPI read frame (CS/SCK generation, SCK divider, shift register, done pulse).
module spi_rx8 import temp_monitor_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       sio,
  output logic       cs_n,
  output logic       sck,
  output logic       idle,
  output logic       done,
  output logic [7:0] data
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] edge_q, edge_d;
  logic cs_q, cs_d, sck_q, sck_d, tick, last;
  logic [7:0] sr_q, sr_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      div_q <= '0;
      edge_q <= '0;
      cs_q <= 1'b1;
      sck_q <= 1'b0;
      sr_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      edge_q <= edge_d;
      cs_q <= cs_d;
      sck_q <= sck_d;
      sr_q <= sr_d;
    end
  assign tick = div_q == DW'(CLK_DIV - 1);
  // 16th divider tick in SHIFT ends the trailing SCK-low phase after bit 8
  assign last = state_q == SHIFT && tick && edge_q == 4'd15;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start ? SETUP : IDLE;
      SETUP: state_d = tick ? SHIFT : SETUP;
      SHIFT: state_d = last ? DONE : SHIFT;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!ena) state_d = IDLE;
  end
  always_comb begin
    div_d = (ena && (state_q == SETUP || state_q == SHIFT) && !tick) ? div_q + DW'(1) : '0;
    edge_d = (ena && state_q == SHIFT) ? (tick ? edge_q + 4'd1 : edge_q) : '0;
    cs_d = !(state_d == SETUP || state_d == SHIFT);
    sck_d = !ena ? 1'b0 :
            (state_q == SETUP && tick) ? 1'b1 :
            (state_q == SHIFT && tick) ? (!last && !sck_q) :
            (state_q == SHIFT) ? sck_q : 1'b0;
    sr_d = !ena ? 8'h00 : (state_q == SHIFT && tick && sck_q) ? {sr_q[6:0], sio} : sr_q;
  end
  assign cs_n = cs_q;
  assign sck = sck_q;
  assign idle = state_q == IDLE;
  assign done = ena && last;
  assign data = sr_q;
endmodule

// File: rtl/temp_monitor_spi_core.sv
// temp_monitor_spi_core: periodic LM70 SPI reader publishing the 8 temperature MSBs on uo_out.
// Define TEMP_MONITOR_ALARM_EN to add the over-temperature alarm on uio_out[3].
module temp_monitor_spi_core import temp_monitor_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int SAMPLE_GAP = 64
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  temp_monitor_spi_core_if.slave bus
);
  localparam int GW = $clog2(SAMPLE_GAP + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] uo_q, uo_d, data, uio;
  logic valid_q, valid_d, alarm, cs_n, sck, idle, done, start;
  spi_rx8 #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .sio(bus.uio_in[UIO_SIO]),
    .cs_n(cs_n), .sck(sck), .idle(idle), .done(done), .data(data)
  );
  assign start = ena && idle && gap_q == GW'(SAMPLE_GAP - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gap_q <= '0;
      uo_q <= '0;
      valid_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      uo_q <= uo_d;
      valid_q <= valid_d;
    end
  always_comb begin
    gap_d = (ena && idle && !start) ? gap_q + GW'(1) : '0;
    uo_d = done ? data : uo_q;
    valid_d = valid_q || done;
  end
`ifdef TEMP_MONITOR_ALARM_EN
  logic alarm_q, alarm_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) alarm_q <= 1'b0;
    else alarm_q <= alarm_d;
  assign alarm_d = done ? $signed(data) > $signed(bus.ui_in) : alarm_q;
  assign alarm = alarm_q;
  logic unused_ok;
  assign unused_ok = ^{bus.uio_in[7:3], bus.uio_in[1:0]};
`else
  assign alarm = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{bus.ui_in, bus.uio_in[7:3], bus.uio_in[1:0]};
`endif
  always_comb begin
    uio = '0;
    uio[UIO_CS] = cs_n;
    uio[UIO_SCK] = sck;
    uio[UIO_ALARM] = alarm;
    uio[UIO_VALID] = valid_q;
  end
  assign bus.uo_out = uo_q;
  assign bus.uio_out = uio;
  assign bus.uio_oe = UIO_OE;
endmodule

// File: tb/tb_temp_monitor_spi_core.sv
// tb_temp_monitor_spi_core: directed scoreboard bench with an LM70 sensor model.
// Alarm expectations follow TEMP_MONITOR_ALARM_EN.
module tb_temp_monitor_spi_core;
  localparam int CLK_DIV = 2;
  localparam int SAMPLE_GAP = 64;
`ifdef TEMP_MONITOR_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
  localparam logic [7:0] EXP_OE = 8'h1B;
  localparam logic [7:0] ZERO_MASK = 8'hE4;
`else
  localparam bit ALARM_EN = 1'b0;
  localparam logic [7:0] EXP_OE = 8'h13;
  localparam logic [7:0] ZERO_MASK = 8'hEC;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, sio = 1'b0;
  logic [7:0] ui = 8'h10;
  logic [15:0] word = 16'h0000, latched = 16'h0000;
  int bitidx = 15, rise_cnt = 0, n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic cs, sck;
  temp_monitor_spi_core_if bus();
  temp_monitor_spi_core #(.CLK_DIV(CLK_DIV), .SAMPLE_GAP(SAMPLE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus)
  );
  assign bus.ui_in = ui;
  assign bus.uio_in = {5'b10101, sio, 2'b11};
  assign cs = bus.uio_out[0];
  assign sck = bus.uio_out[1];
  always #5 clk = ~clk;
  // LM70 model: MSB valid on CS fall, next bit after each SCK fall
  always @(negedge cs) begin
    latched = word;
    bitidx = 15;
    sio = latched[15];
  end
  always @(negedge sck)
    if (!cs && bitidx > 0) begin
      bitidx--;
      sio = latched[bitidx];
    end
  always @(posedge sck) if (!cs) rise_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("uio_oe", bus.uio_oe, EXP_OE);
    chk("unused_uio_out", bus.uio_out & ZERO_MASK, 8'h00);
  end
  task automatic wait_cs(input logic lvl, output int n);
    n = 0;
    while (cs !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cs !== lvl) begin
      n_chk++;
      n_fail++;
      $error("FAIL cs_wait: observed cs=%b expected %b within 1000 clocks", cs, lvl);
    end
  endtask
  task automatic frame(input logic [15:0] w, input int exp_gap, input string tag);
    int n;
    logic [7:0] b;
    word = w;
    rise_cnt = 0;
    wait_cs(1'b0, n);
    chk({tag, "_gap"}, n, exp_gap);
    exp_q.push_back(w[15:8]);
    wait_cs(1'b1, n);
    chk({tag, "_cs_low"}, n, CLK_DIV * 17);
    chk({tag, "_sck_rises"}, rise_cnt, 8);
    b = exp_q.pop_front();
    chk({tag, "_uo_out"}, bus.uo_out, b);
    chk({tag, "_valid"}, bus.uio_out[4], 1'b1);
    chk({tag, "_alarm"}, bus.uio_out[3], ALARM_EN && ($signed(b) > $signed(ui)));
  endtask
  initial begin
    int n;
    @(negedge clk);
    chk("rst_uo_out", bus.uo_out, 8'h00);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_valid", bus.uio_out[4], 1'b0);
    chk("rst_alarm", bus.uio_out[3], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'h1900, SAMPLE_GAP, "f1900");
    frame(16'h0033, SAMPLE_GAP + 1, "f0033");
    frame(16'hE700, SAMPLE_GAP + 1, "fE700");
    frame(16'h3200, SAMPLE_GAP + 1, "f3200");
    word = 16'h5A00;
    wait_cs(1'b0, n);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", cs, 1'b1);
    chk("arst_sck", sck, 1'b0);
    chk("arst_uo_out", bus.uo_out, 8'h00);
    chk("arst_valid", bus.uio_out[4], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'h1900, SAMPLE_GAP, "frec");
    word = 16'h7F00;
    wait_cs(1'b0, n);
    repeat (12) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("ena_cs", cs, 1'b1);
    chk("ena_sck", sck, 1'b0);
    repeat (20) @(negedge clk);
    chk("ena_cs_hold", cs, 1'b1);
    chk("ena_uo_hold", bus.uo_out, 8'h19);
    chk("ena_valid_hold", bus.uio_out[4], 1'b1);
    ena = 1'b1;
    frame(16'h3200, SAMPLE_GAP, "fena");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200us;
    $display("FAIL watchdog: observed no finish expected finish within 200us");
    $fatal(1, "watchdog");
  end
endmodule
